// File: rtl/ram_responder.sv
// ram_responder: block-RAM backed responder for the RAM wrapper handshake.
// After reset it zero-fills every location, then raises rdy. Reads return the
// addressed byte after READ_LATENCY cycles and hold it until read_ack.
// Optional macro RAM_RESP_ADDR_WRAP_EN: when defined, upper address bits are
// ignored (addresses alias modulo DEPTH). When undefined, a write with any
// upper bit set is dropped and a read with any upper bit set returns 8'h00.
module ram_responder #(
  parameter int ADDR_W       = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [25:0] address,
  input  logic [7:0]  data_in,
  input  logic        write_enable,
  input  logic        read_request,
  input  logic        read_ack,
  output logic [7:0]  data_out,
  output logic        rdy,
  output logic        rd_data_pres,
  output logic [25:0] max_ram_address
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(READ_LATENCY - 1);
  localparam logic [LAT_W-1:0]  LAT_ZERO  = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0]  LAT_ONE   = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   FILL_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   FILL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [25:0]       MAX_ADDR  = 26'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_HOLD = 2'd3
  } state_t;

  state_t            state_r, state_s;
  // One extra bit: the MSB marks "every location has been written".
  logic [ADDR_W:0]   fill_cnt_r, fill_cnt_s;
  logic [LAT_W-1:0]  lat_cnt_r, lat_cnt_s;
  logic [7:0]        rd_buf_r, rd_buf_s;
  logic [7:0]        data_out_r, data_out_s;
  logic              rdy_r, rdy_s;
  logic              pres_r, pres_s;

  logic [7:0]        mem_r [DEPTH];

  logic [ADDR_W-1:0] idx_s;
  logic              in_range_s;
  logic              wr_valid_s;
  logic              fill_wr_s;
  logic [7:0]        rd_word_s;

  assign idx_s = address[ADDR_W-1:0];

`ifdef RAM_RESP_ADDR_WRAP_EN
  assign in_range_s = 1'b1;
`else
  assign in_range_s = ((address >> ADDR_W) == 26'd0);
`endif

  // Write port runs independently of the read FSM once the fill is done.
  assign wr_valid_s = write_enable & rdy_r & in_range_s;
  assign fill_wr_s  = (state_r == ST_INIT) & ~fill_cnt_r[ADDR_W];

  // Byte seen by a read accepted this cycle; a same-cycle write wins.
  always_comb begin
    rd_word_s = 8'h00;
    if (!in_range_s) begin
      rd_word_s = 8'h00;
    end else if (wr_valid_s) begin
      rd_word_s = data_in;
    end else begin
      rd_word_s = mem_r[idx_s];
    end
  end

  // Storage array: zero-fill during INIT, initiator writes afterwards.
  always_ff @(posedge clk) begin
    if (fill_wr_s) begin
      mem_r[fill_cnt_r[ADDR_W-1:0]] <= 8'h00;
    end else if (wr_valid_s) begin
      mem_r[idx_s] <= data_in;
    end
  end

  // Control and output registers; reset abandons any fill or read in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_INIT;
      fill_cnt_r <= FILL_ZERO;
      lat_cnt_r  <= LAT_ZERO;
      rd_buf_r   <= 8'h00;
      data_out_r <= 8'h00;
      rdy_r      <= 1'b0;
      pres_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      fill_cnt_r <= fill_cnt_s;
      lat_cnt_r  <= lat_cnt_s;
      rd_buf_r   <= rd_buf_s;
      data_out_r <= data_out_s;
      rdy_r      <= rdy_s;
      pres_r     <= pres_s;
    end
  end

  // Next-state and next-output logic of the fill / read handshake FSM.
  always_comb begin
    state_s    = state_r;
    fill_cnt_s = fill_cnt_r;
    lat_cnt_s  = lat_cnt_r;
    rd_buf_s   = rd_buf_r;
    data_out_s = data_out_r;
    rdy_s      = rdy_r;
    pres_s     = pres_r;
    case (state_r)
      ST_INIT: begin
        if (fill_cnt_r[ADDR_W]) begin
          rdy_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          fill_cnt_s = fill_cnt_r + FILL_ONE;
        end
      end
      ST_IDLE: begin
        if (read_request) begin
          rd_buf_s  = rd_word_s;
          lat_cnt_s = LAT_LOAD;
          state_s   = ST_RD_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (lat_cnt_r == LAT_ZERO) begin
          data_out_s = rd_buf_r;
          pres_s     = 1'b1;
          state_s    = ST_RD_HOLD;
        end else begin
          lat_cnt_s = lat_cnt_r - LAT_ONE;
        end
      end
      ST_RD_HOLD: begin
        if (read_ack) begin
          pres_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RD_HOLD;
        end
      end
      default: begin
        state_s = ST_INIT;
      end
    endcase
  end

  assign data_out        = data_out_r;
  assign rdy             = rdy_r;
  assign rd_data_pres    = pres_r;
  assign max_ram_address = MAX_ADDR;

endmodule
